// File: rtl/watch_time_gen.sv
// Watch time base: divider-driven hh:mm:ss.cc counter with optional button setting.
// Define WATCH_SET_EN to compile in the hour/minute/second set buttons.
module watch_time_gen #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned INIT_HOUR = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_run,
  input  logic        i_clear,
  input  logic        i_btn_hour,
  input  logic        i_btn_min,
  input  logic        i_btn_sec,
  output logic [23:0] o_time,
  output logic        o_sec_tick
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [4:0]    hour, hour_nxt;
  logic [5:0]    minute, minute_nxt;
  logic [5:0]    sec, sec_nxt;
  logic [6:0]    msec, msec_nxt;
  logic          tick;
  logic          msec_wrap, sec_carry, min_carry;
  logic          btn_sec_edge, btn_min_edge, btn_hour_edge;

`ifdef WATCH_SET_EN
  // armed = button seen low last cycle; resetting to 0 means a button held
  // through reset must be released before it can count.
  logic [2:0] btn_armed;

  assign btn_sec_edge  = i_btn_sec  & btn_armed[0];
  assign btn_min_edge  = i_btn_min  & btn_armed[1];
  assign btn_hour_edge = i_btn_hour & btn_armed[2];

  always_ff @(posedge clk) begin
    if (rst) btn_armed <= '0;
    else     btn_armed <= ~{i_btn_hour, i_btn_min, i_btn_sec};
  end
`else
  logic unused_btns;
  assign unused_btns   = ^{i_btn_hour, i_btn_min, i_btn_sec};
  assign btn_sec_edge  = 1'b0;
  assign btn_min_edge  = 1'b0;
  assign btn_hour_edge = 1'b0;
`endif

  assign tick = i_run && (div_cnt == DIV_LAST);

  // A button edge on a field absorbs any incoming carry and blocks the onward one.
  always_comb begin
    msec_wrap  = tick && (msec == 7'd99);
    msec_nxt   = msec;
    sec_nxt    = sec;
    minute_nxt = minute;
    hour_nxt   = hour;
    if (tick) msec_nxt = msec_wrap ? '0 : msec + 7'd1;

    if (msec_wrap || btn_sec_edge) sec_nxt = (sec == 6'd59) ? '0 : sec + 6'd1;
    sec_carry = msec_wrap && !btn_sec_edge && (sec == 6'd59);

    if (sec_carry || btn_min_edge) minute_nxt = (minute == 6'd59) ? '0 : minute + 6'd1;
    min_carry = sec_carry && !btn_min_edge && (minute == 6'd59);

    if (min_carry || btn_hour_edge) hour_nxt = (hour == 5'd23) ? '0 : hour + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      div_cnt    <= '0;
      hour       <= 5'(INIT_HOUR);
      minute     <= '0;
      sec        <= '0;
      msec       <= '0;
      o_sec_tick <= 1'b0;
    end else begin
      if (i_run) div_cnt <= tick ? '0 : div_cnt + 1'b1;
      hour       <= hour_nxt;
      minute     <= minute_nxt;
      sec        <= sec_nxt;
      msec       <= msec_nxt;
      o_sec_tick <= msec_wrap;
    end
  end

  assign o_time = {hour, minute, sec, msec};

endmodule

// File: tb/tb_watch_time_gen.sv
// Bench for watch_time_gen: table vectors, directed corner sequences and a random
// run against a centisecond-of-day reference model. Honours WATCH_SET_EN.
module tb_watch_time_gen;

  logic        clk = 1'b0;
  logic        rst, run, clear;
  logic [2:0]  btn;                 // {hour, min, sec}
  logic [23:0] t_main, t_fast;
  logic        st_main, st_fast;

  always #5 clk = ~clk;

  watch_time_gen #(.CLK_FREQ(1000), .TICK_HZ(100), .INIT_HOUR(12)) u_dut (
    .clk(clk), .rst(rst), .i_run(run), .i_clear(clear),
    .i_btn_hour(btn[2]), .i_btn_min(btn[1]), .i_btn_sec(btn[0]),
    .o_time(t_main), .o_sec_tick(st_main)
  );

  watch_time_gen #(.CLK_FREQ(100), .TICK_HZ(100), .INIT_HOUR(5)) u_fast (
    .clk(clk), .rst(rst), .i_run(run), .i_clear(clear),
    .i_btn_hour(btn[2]), .i_btn_min(btn[1]), .i_btn_sec(btn[0]),
    .o_time(t_fast), .o_sec_tick(st_fast)
  );

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  // Reference model state, one slot per instance.
  int m_div[2]  = '{10, 1};
  int m_init[2] = '{12, 5};
  int m_h[2], m_m[2], m_s[2], m_ms[2], m_ph[2];
  bit m_tick[2];
  bit prev[3] = '{1'b1, 1'b1, 1'b1};

  typedef struct {
    bit          rst;
    bit          run;
    bit          clear;
    int          n;
    logic [23:0] exp;
    int          pulses;
  } vec_t;

  function automatic logic [23:0] pack(int h, int m, int s, int ms);
    return {5'(h), 6'(m), 6'(s), 7'(ms)};
  endfunction

  function automatic vec_t mk(bit r, bit ru, bit c, int n, logic [23:0] e, int p);
    vec_t v;
    v.rst = r; v.run = ru; v.clear = c; v.n = n; v.exp = e; v.pulses = p;
    return v;
  endfunction

  task automatic check(string name, logic [23:0] act, logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h (%0d:%0d:%0d.%0d) expected %h (%0d:%0d:%0d.%0d)",
               name, act, act[23:19], act[18:13], act[12:7], act[6:0],
               exp, exp[23:19], exp[18:13], exp[12:7], exp[6:0]);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counting is done on a single centisecond-of-day number; button edges then
  // overwrite their field with old+1 and cancel anything counting did above it.
  task automatic model_step();
    bit ed[3];
    for (int i = 0; i < 3; i++) begin
      ed[i]   = btn[i] && !prev[i];
      prev[i] = rst ? 1'b1 : btn[i];
    end
    for (int k = 0; k < 2; k++) begin
      if (rst || clear) begin
        m_h[k] = m_init[k]; m_m[k] = 0; m_s[k] = 0; m_ms[k] = 0;
        m_ph[k] = 0; m_tick[k] = 1'b0;
      end else begin
        int  cs, nh, nm, ns, nms;
        bit  tk;
        tk = run && (m_ph[k] == m_div[k] - 1);
        if (run) m_ph[k] = (m_ph[k] + 1) % m_div[k];
        cs = ((m_h[k] * 60 + m_m[k]) * 60 + m_s[k]) * 100 + m_ms[k];
        if (tk) cs = (cs + 1) % 8640000;
        nms = cs % 100;
        ns  = (cs / 100) % 60;
        nm  = (cs / 6000) % 60;
        nh  = cs / 360000;
        m_tick[k] = tk && (m_ms[k] == 99);
`ifdef WATCH_SET_EN
        if (ed[0]) begin ns = (m_s[k] + 1) % 60; nm = m_m[k]; nh = m_h[k]; end
        if (ed[1]) begin nm = (m_m[k] + 1) % 60; nh = m_h[k]; end
        if (ed[2]) nh = (m_h[k] + 1) % 24;
`endif
        m_h[k] = nh; m_m[k] = nm; m_s[k] = ns; m_ms[k] = nms;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (st_main) pulses++;
    check("main_model", t_main, pack(m_h[0], m_m[0], m_s[0], m_ms[0]));
    check_int("main_sec_tick", int'(st_main), int'(m_tick[0]));
    check("fast_model", t_fast, pack(m_h[1], m_m[1], m_s[1], m_ms[1]));
    check_int("fast_sec_tick", int'(st_fast), int'(m_tick[1]));
  endtask

  task automatic run_cycles(int n);
    repeat (n) cycle();
  endtask

  task automatic do_clear();
    clear = 1'b1; cycle(); clear = 1'b0;
  endtask

`ifdef WATCH_SET_EN
  task automatic press(int which);
    btn[which] = 1'b1; cycle();
    btn[which] = 1'b0; cycle();
  endtask
`endif

  vec_t vt[15];

  initial begin
    rst = 1'b1; run = 1'b0; clear = 1'b0; btn = '0;
    @(negedge clk);
    run_cycles(2);
    rst = 1'b0;
    check("reset_main", t_main, pack(12, 0, 0, 0));
    check_int("reset_sec_tick", int'(st_main), 0);
    check("reset_fast", t_fast, pack(5, 0, 0, 0));

    vt[0]  = mk(0, 0, 1, 1,    pack(12, 0, 0, 0), 0);
    vt[1]  = mk(0, 1, 0, 10,   pack(12, 0, 0, 1), 0);
    vt[2]  = mk(0, 0, 0, 25,   pack(12, 0, 0, 1), 0);
    vt[3]  = mk(0, 1, 0, 5,    pack(12, 0, 0, 1), 0);
    vt[4]  = mk(0, 1, 0, 5,    pack(12, 0, 0, 2), 0);
    vt[5]  = mk(0, 1, 0, 3,    pack(12, 0, 0, 2), 0);
    vt[6]  = mk(0, 1, 1, 1,    pack(12, 0, 0, 0), 0);
    vt[7]  = mk(0, 1, 0, 9,    pack(12, 0, 0, 0), 0);
    vt[8]  = mk(0, 1, 0, 1,    pack(12, 0, 0, 1), 0);
    vt[9]  = mk(0, 1, 0, 990,  pack(12, 0, 1, 0), 1);
    vt[10] = mk(1, 1, 0, 1,    pack(12, 0, 0, 0), 0);
    vt[11] = mk(0, 1, 0, 1000, pack(12, 0, 1, 0), 1);
    vt[12] = mk(0, 1, 0, 4,    pack(12, 0, 1, 0), 0);
    vt[13] = mk(1, 1, 0, 1,    pack(12, 0, 0, 0), 0);
    vt[14] = mk(0, 1, 0, 10,   pack(12, 0, 0, 1), 0);

    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst; run = vt[i].run; clear = vt[i].clear;
      pulses = 0;
      run_cycles(vt[i].n);
      rst = 1'b0; clear = 1'b0;
      check($sformatf("vec%0d_time", i), t_main, vt[i].exp);
      check_int($sformatf("vec%0d_pulses", i), pulses, vt[i].pulses);
    end
    run = 1'b0;

`ifdef WATCH_SET_EN
    // Preload 23:59:59, count msec to 99, then one tick wraps the whole day.
    do_clear();
    repeat (11) press(2);
    repeat (59) press(1);
    repeat (59) press(0);
    check("preload_hms", t_main, pack(23, 59, 59, 0));
    run = 1'b1;
    run_cycles(990);
    check("preload_full", t_main, pack(23, 59, 59, 99));
    pulses = 0;
    run_cycles(10);
    check("day_wrap", t_main, pack(0, 0, 0, 0));
    check_int("day_wrap_pulses", pulses, 1);
    run = 1'b0;

    // 61 minute presses while frozen: wraps once, no carry into hour.
    do_clear();
    run = 1'b1; run_cycles(30); run = 1'b0;
    repeat (61) press(1);
    check("min_61_presses", t_main, pack(12, 1, 0, 3));

    // Second button coincident with msec 99->0 carry at sec=58.
    do_clear();
    repeat (58) press(0);
    run = 1'b1;
    run_cycles(999);
    check("sec_carry_setup", t_main, pack(12, 0, 58, 99));
    btn[0] = 1'b1;
    cycle();
    check("sec_btn_carry", t_main, pack(12, 0, 59, 0));
    check_int("sec_btn_carry_tick", int'(st_main), 1);
    btn[0] = 1'b0;
    run = 1'b0;
    cycle();

    // Clear wins over a tick and an hour edge in the same cycle.
    do_clear();
    run = 1'b1; run_cycles(9);
    clear = 1'b1; btn[2] = 1'b1;
    cycle();
    check("clear_priority", t_main, pack(12, 0, 0, 0));
    clear = 1'b0; btn = '0; run = 1'b0;
    cycle();

    // Held button counts once; simultaneous edges each apply.
    btn[0] = 1'b1; run_cycles(20); btn[0] = 1'b0; cycle();
    check("held_once", t_main, pack(12, 0, 1, 0));
    btn = 3'b111; cycle(); btn = '0; cycle();
    check("simultaneous", t_main, pack(13, 1, 2, 0));

    // Button held through reset release must not count.
    btn[2] = 1'b1; rst = 1'b1; cycle(); rst = 1'b0;
    run_cycles(5);
    btn[2] = 1'b0; cycle();
    check("held_thru_reset", t_main, pack(12, 0, 0, 0));
`else
    do_clear();
    run = 1'b1; run_cycles(30); run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn = 3'($urandom);
      cycle();
      check($sformatf("btn_ignored%0d", i), t_main, pack(12, 0, 0, 3));
    end
    btn = '0;
`endif

    // Random run checked cycle by cycle against the reference model.
    for (int i = 0; i < 20000; i++) begin
      run   = ($urandom % 8) != 0;
      clear = ($urandom % 4000) == 0;
      rst   = ($urandom % 9000) == 0;
      for (int b = 0; b < 3; b++)
        if (($urandom % 6) == 0) btn[b] = ~btn[b];
      cycle();
    end
    rst = 1'b0; clear = 1'b0; run = 1'b0; btn = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
